// File: rtl/motor_pwm_driver.sv
// Dual-wheel H-bridge PWM stage: signed duty commands via valid/ready, boundary-aligned updates, dead time, saturation.
// Optional watchdog built when WATCHDOG_EN is defined; otherwise wd_trip is tied low.
module motor_pwm_driver #(
  parameter int DUTY_W       = 8,
  parameter int PRESC        = 1,
  parameter int DEAD_CYC     = 16,
  parameter int WDOG_PERIODS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] r_duty,
  input  logic [DUTY_W-1:0] l_duty,
  output logic              enA,
  output logic              In1,
  output logic              In2,
  output logic              enB,
  output logic              In3,
  output logic              In4,
  output logic              period_start,
  output logic              wd_trip
);
  // state    | meaning
  // COAST    | bridge off, duty is zero
  // FWD      | In=10, PWM on enable
  // REV      | In=01, PWM on enable
  // DEAD     | bridge off while waiting out a reversal
  localparam logic [1:0] ST_COAST = 2'd0;
  localparam logic [1:0] ST_FWD   = 2'd1;
  localparam logic [1:0] ST_REV   = 2'd2;
  localparam logic [1:0] ST_DEAD  = 2'd3;

  localparam int PERIOD = 2**(DUTY_W-1) - 1;
  localparam int CW     = DUTY_W - 1;
  localparam int PW     = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int DW     = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DUTY_W-1:0] MOST_NEG = {1'b1, {(DUTY_W-1){1'b0}}};
  localparam logic [DUTY_W-1:0] SAT_NEG  = MOST_NEG | DUTY_W'(1);

  logic [PW-1:0]     presc_cnt;
  logic [CW-1:0]     cnt;
  logic              tick, boundary, accept, ready_en, shadow_full, wd_fire;
  logic [DUTY_W-1:0] r_sat, l_sat, sh_r, sh_l, act_r, act_l;
  logic [1:0]        en_v, ina_v, inb_v;

  assign tick      = (presc_cnt == PW'(PRESC-1));
  assign boundary  = tick && (cnt == CW'(PERIOD-1));
  assign cmd_ready = ready_en && !shadow_full;
  assign accept    = cmd_valid && cmd_ready;
  assign r_sat     = (r_duty == MOST_NEG) ? SAT_NEG : r_duty;
  assign l_sat     = (l_duty == MOST_NEG) ? SAT_NEG : l_duty;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt    <= '0;
      cnt          <= '0;
      ready_en     <= 1'b0;
      shadow_full  <= 1'b0;
      period_start <= 1'b0;
      sh_r         <= '0;
      sh_l         <= '0;
      act_r        <= '0;
      act_l        <= '0;
    end else begin
      ready_en     <= 1'b1;
      period_start <= tick && (cnt == '0);
      if (tick) begin
        presc_cnt <= '0;
        cnt       <= boundary ? '0 : cnt + CW'(1);
      end else begin
        presc_cnt <= presc_cnt + PW'(1);
      end
      if (accept) begin
        sh_r        <= r_sat;
        sh_l        <= l_sat;
        shadow_full <= 1'b1;
      end else if (boundary && shadow_full) begin
        act_r       <= sh_r;
        act_l       <= sh_l;
        shadow_full <= 1'b0;
      end
      if (wd_fire) begin
        act_r <= '0;
        act_l <= '0;
      end
    end
  end

`ifdef WATCHDOG_EN
  localparam int WW = $clog2(WDOG_PERIODS + 1);
  logic [WW-1:0] wd_cnt;

  // An accept on a boundary edge restarts the count instead of counting that boundary.
  assign wd_fire = boundary && !accept && !wd_trip && (wd_cnt == WW'(WDOG_PERIODS-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt  <= '0;
      wd_trip <= 1'b0;
    end else if (accept) begin
      wd_cnt  <= '0;
      wd_trip <= 1'b0;
    end else if (boundary && !wd_trip) begin
      if (wd_fire) wd_trip <= 1'b1;
      else         wd_cnt  <= wd_cnt + WW'(1);
    end
  end
`else
  assign wd_fire = 1'b0;
  assign wd_trip = 1'b0;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [DUTY_W-1:0] d;
    logic [1:0]        state, state_nx;
    logic [DW-1:0]     dead_cnt, dead_nx;
    logic              tgt_rev, tgt_nx, pos, neg, zero, en_q, ina_q, inb_q;
    logic [CW-1:0]     mag, mag_q;

    assign d    = (g == 0) ? act_r : act_l;
    assign neg  = d[DUTY_W-1];
    assign zero = (d == '0);
    assign pos  = !neg && !zero;
    assign mag  = neg ? CW'(-d) : CW'(d);

    always_comb begin
      state_nx = state;
      dead_nx  = dead_cnt;
      tgt_nx   = tgt_rev;
      case (state)
        ST_COAST: begin
          if (pos)      state_nx = ST_FWD;
          else if (neg) state_nx = ST_REV;
        end
        ST_FWD: begin
          if (zero) state_nx = ST_COAST;
          else if (neg) begin
            state_nx = ST_DEAD;
            tgt_nx   = 1'b1;
            dead_nx  = DW'(DEAD_CYC-1);
          end
        end
        ST_REV: begin
          if (zero) state_nx = ST_COAST;
          else if (pos) begin
            state_nx = ST_DEAD;
            tgt_nx   = 1'b0;
            dead_nx  = DW'(DEAD_CYC-1);
          end
        end
        default: begin
          if (zero) begin
            state_nx = ST_COAST;
          end else if (neg == tgt_rev) begin
            if (dead_cnt == '0) state_nx = neg ? ST_REV : ST_FWD;
            else                dead_nx  = dead_cnt - DW'(1);
          end else begin
            // Target flipped mid dead time: the full dead time restarts toward the new sign.
            tgt_nx  = neg;
            dead_nx = DW'(DEAD_CYC-1);
          end
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state    <= ST_COAST;
        dead_cnt <= '0;
        tgt_rev  <= 1'b0;
        mag_q    <= '0;
        en_q     <= 1'b0;
        ina_q    <= 1'b0;
        inb_q    <= 1'b0;
      end else begin
        state    <= state_nx;
        dead_cnt <= dead_nx;
        tgt_rev  <= tgt_nx;
        mag_q    <= mag;
        en_q     <= ((state == ST_FWD) || (state == ST_REV)) && (cnt < mag_q);
        ina_q    <= (state == ST_FWD);
        inb_q    <= (state == ST_REV);
      end
    end

    assign en_v[g]  = en_q;
    assign ina_v[g] = ina_q;
    assign inb_v[g] = inb_q;
  end

  assign enA = en_v[0];
  assign In1 = ina_v[0];
  assign In2 = inb_v[0];
  assign enB = en_v[1];
  assign In3 = ina_v[1];
  assign In4 = inb_v[1];
endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver: duty vector table plus dead-time, back-to-back, reset and watchdog sequences.
module tb_motor_pwm_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic signed [7:0] r_duty = 8'sd0;
  logic signed [7:0] l_duty = 8'sd0;
  logic enA, In1, In2, enB, In3, In4, period_start, wd_trip;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  motor_pwm_driver #(.DUTY_W(8), .PRESC(1), .DEAD_CYC(16), .WDOG_PERIODS(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .r_duty(r_duty), .l_duty(l_duty),
    .enA(enA), .In1(In1), .In2(In2), .enB(enB), .In3(In3), .In4(In4),
    .period_start(period_start), .wd_trip(wd_trip)
  );

  typedef struct {
    logic signed [7:0] r;
    logic signed [7:0] l;
    logic [3:0]        pins;
    int                duty_a;
    int                duty_b;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pins();
    return int'({In1, In2, In3, In4});
  endfunction

  task automatic send(input logic signed [7:0] r, input logic signed [7:0] l, input string name);
    int ok;
    @(negedge clk);
    cmd_valid = 1'b1;
    r_duty = r;
    l_duty = l;
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check({name, "_accept"}, ok, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_xfer(input string name);
    int ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    check({name, "_xfer"}, ok, 1);
  endtask

  task automatic wait_pstart(input string name);
    int ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (period_start) begin ok = 1; break; end
    end
    check({name, "_pstart"}, ok, 1);
  endtask

  task automatic window(output int na, output int nb, output int p0, output int changes);
    na = 0; nb = 0; changes = 0;
    @(negedge clk);
    p0 = pins();
    na += int'(enA);
    nb += int'(enB);
    for (int i = 1; i < 127; i++) begin
      @(negedge clk);
      if (pins() != p0) changes++;
      na += int'(enA);
      nb += int'(enB);
    end
  endtask

  initial begin
    int na, nb, p0, ch, n, coast, left_bad, bad;
    vecs[0] = '{8'sd32,   8'sd0,    4'b1000, 32,  0};
    vecs[1] = '{8'h80,    8'sd5,    4'b0110, 127, 5};
    vecs[2] = '{8'sd60,   -8'sd7,   4'b1001, 60,  7};
    vecs[3] = '{8'sd0,    -8'sd127, 4'b0001, 0,   127};
    vecs[4] = '{-8'sd1,   8'sd126,  4'b0110, 1,   126};
    vecs[5] = '{8'sd127,  8'h80,    4'b1001, 127, 127};
    vecs[6] = '{8'sd60,   -8'sd7,   4'b1001, 60,  7};

    // Reset values
    repeat (4) @(negedge clk);
    check("rst_pins", pins(), 0);
    check("rst_en", int'({enA, enB}), 0);
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_pstart", int'(period_start), 0);
    check("rst_wd", int'(wd_trip), 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", int'(cmd_ready), 1);

    foreach (vecs[k]) begin
      send(vecs[k].r, vecs[k].l, $sformatf("vec%0d", k));
      wait_xfer($sformatf("vec%0d", k));
      repeat (24) @(negedge clk);
      window(na, nb, p0, ch);
      check($sformatf("vec%0d_pins", k), p0, int'(vecs[k].pins));
      check($sformatf("vec%0d_duty_a", k), na, vecs[k].duty_a);
      check($sformatf("vec%0d_duty_b", k), nb, vecs[k].duty_b);
      check($sformatf("vec%0d_pin_changes", k), ch, 0);
    end

    // Reversal +60 -> -60 on the right wheel only
    send(-8'sd60, -8'sd7, "dead");
    wait_xfer("dead");
    n = 0;
    left_bad = 0;
    while ({In1, In2} != 2'b00 && n < 10) begin @(negedge clk); n++; end
    coast = 0;
    while ({In1, In2} == 2'b00 && !enA && coast < 100) begin
      if ({In3, In4} != 2'b01) left_bad++;
      coast++;
      @(negedge clk);
    end
    check("dead_len", coast, 16);
    check("dead_after_dir", int'({In1, In2}), 2'b01);
    check("dead_left_unaffected", left_bad, 0);
    repeat (4) @(negedge clk);
    window(na, nb, p0, ch);
    check("dead_duty_a", na, 60);
    check("dead_duty_b", nb, 7);

    // Back-to-back commands inside one period
    wait_pstart("b2b");
    send(-8'sd10, -8'sd7, "b2b1");
    cmd_valid = 1'b1;
    r_duty = -8'sd90;
    l_duty = -8'sd7;
    @(negedge clk);
    check("b2b_blocked", int'(cmd_ready), 0);
    n = 0;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    check("b2b_ready_seen", int'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_accept_with_pstart", int'(period_start), 1);
    window(na, nb, p0, ch);
    check("b2b_first_duty", na, 10);
    wait_xfer("b2b2");
    repeat (4) @(negedge clk);
    window(na, nb, p0, ch);
    check("b2b_second_duty", na, 90);

    // Reset in mid-period with a pending shadow command
    send(8'sd127, 8'sd127, "rstmid");
    wait_xfer("rstmid");
    repeat (24) @(negedge clk);
    wait_pstart("rstmid");
    send(8'sd50, 8'sd50, "rstmid_pending");
    @(negedge clk);
    check("rstmid_enA_before", int'(enA), 1);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_pins", pins(), 0);
    check("rstmid_en", int'({enA, enB}), 0);
    check("rstmid_ready", int'(cmd_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_ready_after", int'(cmd_ready), 1);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (enA || enB || pins() != 0) bad++;
    end
    check("rstmid_stays_coast", bad, 0);

`ifdef WATCHDOG_EN
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_pstart("wd");
    send(8'sd50, 8'sd0, "wd");
    n = 0;
    for (int i = 0; i < 1000 && n < 4; i++) begin
      @(negedge clk);
      if (period_start) begin
        n++;
        if (n == 3) check("wd_not_yet", int'(wd_trip), 0);
      end
    end
    check("wd_boundaries", n, 4);
    check("wd_tripped", int'(wd_trip), 1);
    repeat (3) @(negedge clk);
    window(na, nb, p0, ch);
    check("wd_enA_off", na, 0);
    check("wd_pins_coast", p0, 0);
    send(8'sd20, 8'sd0, "wd_new");
    @(negedge clk);
    check("wd_cleared", int'(wd_trip), 0);
    wait_xfer("wd_new");
    repeat (4) @(negedge clk);
    window(na, nb, p0, ch);
    check("wd_new_duty", na, 20);
`else
    check("wd_tied_low", int'(wd_trip), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
